// File: rtl/sect163r2_pt_chk.sv
// Curve-membership checker for sect163r2 points: y*(y^x) == x*x*(x^1) ^ b over GF(2^163).
// Optional macro SECT163R2_PT_CHK_INF_EN treats (0,0) as the point at infinity (reported on-curve).
module sect163r2_pt_chk (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [162:0] x,
    input  logic [162:0] y,
    output logic         done,
    output logic         on_curve
);

    localparam logic [162:0] B_CONST = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;
    localparam logic [162:0] RED_TAP = 163'hC9;
    localparam logic [7:0]   CNT_TOP = 8'd162;

    typedef enum logic [2:0] {IDLE, M1, M2, M3, CMP} state_t;

    state_t       state, state_next;
    logic [7:0]   cnt;
    logic [162:0] acc, t1, t2, xr, yr;
    logic [162:0] op_a, op_b, acc_shift, acc_next;
    logic         op_bit, start_inf;

`ifdef SECT163R2_PT_CHK_INF_EN
    assign start_inf = ~|{x, y};
`else
    assign start_inf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = start_inf ? CMP : M1;
            M1:   if (cnt == 8'd0) state_next = M2;
            M2:   if (cnt == 8'd0) state_next = M3;
            M3:   if (cnt == 8'd0) state_next = CMP;
            CMP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    // One MSB-first multiply step; the operand pair depends on which product is in flight.
    always_comb begin
        op_a = yr;
        op_b = yr ^ xr;
        case (state)
            M2: begin
                op_a = xr;
                op_b = xr;
            end
            M3: begin
                op_a = t2;
                op_b = {xr[162:1], ~xr[0]};
            end
            default: ;
        endcase
        op_bit    = op_b[cnt];
        acc_shift = {acc[161:0], 1'b0} ^ (acc[162] ? RED_TAP : '0);
        acc_next  = acc_shift ^ (op_bit ? op_a : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            t1       <= '0;
            t2       <= '0;
            xr       <= '0;
            yr       <= '0;
            done     <= 1'b0;
            on_curve <= 1'b0;
        end else if (clr) begin
            done     <= 1'b0;
            on_curve <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr       <= x;
                        yr       <= y;
                        acc      <= '0;
                        cnt      <= CNT_TOP;
                        on_curve <= 1'b0;
                        // Forcing t1 = b with acc = 0 makes the compare succeed for infinity.
                        if (start_inf) t1 <= B_CONST;
                    end
                end
                M1, M2, M3: begin
                    if (cnt == 8'd0) begin
                        cnt <= CNT_TOP;
                        if (state == M1) begin
                            t1  <= acc_next;
                            acc <= '0;
                        end else if (state == M2) begin
                            t2  <= acc_next;
                            acc <= '0;
                        end else begin
                            acc <= acc_next;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                        acc <= acc_next;
                    end
                end
                CMP: begin
                    done     <= 1'b1;
                    on_curve <= (t1 == (acc ^ B_CONST));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sect163r2_pt_chk.sv
// Self-checking bench for sect163r2_pt_chk: vector table, hand sequences, and random points vs a GF(2^163) model.
module tb_sect163r2_pt_chk;

    localparam logic [162:0] B_CONST = 163'h20A601907B8C953CA1481EB10512F78744A3205FD;
    localparam logic [162:0] GX      = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
    localparam logic [162:0] GY      = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;
    localparam logic [163:0] FPOLY   = (164'd1 << 163) | 164'hC9;
    localparam int           WINDOW  = 560;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [162:0] x = '0;
    logic [162:0] y = '0;
    logic         done;
    logic         on_curve;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [162:0] vx;
        logic [162:0] vy;
        int           exp_on;
        int           exp_lat;
    } vec_t;

    vec_t vecs[4];

    sect163r2_pt_chk dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .start    (start),
        .x        (x),
        .y        (y),
        .done     (done),
        .on_curve (on_curve)
    );

    always #5 clk = ~clk;

    // Schoolbook polynomial product followed by long division by f.
    function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
        logic [325:0] p;
        p = '0;
        for (int i = 0; i < 163; i++)
            if (b[i]) p = p ^ ({163'b0, a} << i);
        for (int i = 325; i >= 163; i--)
            if (p[i]) p = p ^ (326'(FPOLY) << (i - 163));
        return p[162:0];
    endfunction

    function automatic int model_on(input logic [162:0] px, input logic [162:0] py);
        logic [162:0] lhs, rhs;
`ifdef SECT163R2_PT_CHK_INF_EN
        if (px == '0 && py == '0) return 1;
`endif
        lhs = gf_mul(py, py ^ px);
        rhs = gf_mul(gf_mul(px, px), px ^ 163'd1) ^ B_CONST;
        return (lhs == rhs) ? 1 : 0;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[162:0];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Launches one check and watches a fixed window, optionally injecting start/clr/reset mid-run.
    task automatic applyStimulus(input logic [162:0] ox, input logic [162:0] oy,
                                 input int restart_at, input int clr_at, input int rst_at,
                                 output int lat, output int n_done);
        int cycles;
        lat    = 0;
        n_done = 0;
        cycles = 0;
        @(posedge clk);
        #1;
        x = ox;
        y = oy;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cycles < WINDOW) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                n_done++;
                if (lat == 0) lat = cycles;
            end
            start = (cycles == restart_at);
            if (cycles == restart_at) begin
                x = GX ^ (163'd1 << 162);
                y = GY;
            end
            clr = (cycles == clr_at);
            if (cycles == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("rst_mid_done", int'(done), 0);
                checkOutput("rst_mid_on", int'(on_curve), 0);
                #5;
                rst_n = 1'b1;
                break;
            end
        end
        start = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        int lat, n_done;
        logic [162:0] rx, ry;

        vecs[0] = '{GX, GY, 1, 490};
        vecs[1] = '{GX, GY ^ 163'd1, 0, 490};
        vecs[2] = '{GX ^ (163'd1 << 162), GY, 0, 490};
`ifdef SECT163R2_PT_CHK_INF_EN
        vecs[3] = '{163'd0, 163'd0, 1, 1};
`else
        vecs[3] = '{163'd0, 163'd0, 0, 490};
`endif

        #12;
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_on", int'(on_curve), 0);
        #4;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].vx, vecs[i].vy, -1, -1, -1, lat, n_done);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("vec%0d_ndone", i), n_done, 1);
            checkOutput($sformatf("vec%0d_on", i), int'(on_curve), vecs[i].exp_on);
        end

        applyStimulus(GX, GY, 100, -1, -1, lat, n_done);
        checkOutput("restart_latency", lat, 490);
        checkOutput("restart_ndone", n_done, 1);
        checkOutput("restart_on", int'(on_curve), 1);

        applyStimulus(GX, GY, -1, 200, -1, lat, n_done);
        checkOutput("clr_ndone", n_done, 0);
        checkOutput("clr_on", int'(on_curve), 0);
        applyStimulus(GX, GY, -1, -1, -1, lat, n_done);
        checkOutput("after_clr_latency", lat, 490);
        checkOutput("after_clr_on", int'(on_curve), 1);

        // on_curve is high here; reset must drop it with no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_on", int'(on_curve), 0);
        checkOutput("async_rst_done", int'(done), 0);
        #4;
        rst_n = 1'b1;

        applyStimulus(GX ^ (163'd1 << 5), GY, -1, -1, 300, lat, n_done);
        checkOutput("rst_ndone", n_done, 0);
        applyStimulus(GX, GY, -1, -1, -1, lat, n_done);
        checkOutput("after_rst_latency", lat, 490);
        checkOutput("after_rst_on", int'(on_curve), 1);

        for (int k = 0; k < 6; k++) begin
            rx = rand163();
            ry = (k % 2 == 0) ? GY ^ (rand163() & 163'hFF) : rand163();
            applyStimulus(rx, ry, -1, -1, -1, lat, n_done);
            checkOutput($sformatf("rand%0d_latency", k), lat, 490);
            checkOutput($sformatf("rand%0d_on", k), int'(on_curve), model_on(rx, ry));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sect163r2_pt_chk.md
# sect163r2_pt_chk

Downstream checker for the sect163r2 point multiplier. It takes the affine result (x, y) produced by `sect163r2_pt_mul` and tests whether it satisfies the curve equation y² + xy = x³ + x² + b over GF(2^163), with reduction polynomial f = z^163 + z^7 + z^6 + z^3 + 1. The test uses a single bit-serial multiplier, runs three multiplications in sequence and flags the result as a fault-detection status. Its control handshake matches the multiplier's, so `done` from the multiplier can drive `start` here directly.

## Interface
- No parameters. The curve constant b = 0x20A601907B8C953CA1481EB10512F78744A3205FD is fixed internally.
- `clk` input, 1 bit: system clock. This is the single clock domain.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `clr` input, 1 bit: synchronous clear. It aborts any operation and returns the block to IDLE.
- `start` input, 1 bit: one-cycle request. It is sampled only in IDLE.
- `x` input, 163 bits: affine x coordinate, captured on the accepted `start`.
- `y` input, 163 bits: affine y coordinate, captured on the accepted `start`.
- `done` output, 1 bit: one-cycle pulse when a result is ready.
- `on_curve` output, 1 bit: check result. It is valid from `done` and held until the next accepted `start`, `clr` or reset.

## Operation
- Rewritten identity: y·(y ⊕ x) == x·x·(x ⊕ 1) ⊕ b. Here ⊕ is XOR and x ⊕ 1 flips bit 0.
- Multiplier, MSB-first, one step per cycle:
  - acc ← (acc << 1 reduced mod f) ⊕ (bit_i(B) ? A : 0), for i = 162 down to 0.
  - Reduction: if acc[162] = 1, the shifted value drops bit 163 and is XORed with 0xC9.
- States:
  - IDLE: on `start`, latch x and y, clear acc, set bit counter to 162, go to M1.
  - M1: A = y, B = y ⊕ x. At counter 0, store t1 = acc, clear acc, reload counter, go to M2.
  - M2: A = x, B = x. At counter 0, store t2, go to M3.
  - M3: A = t2, B = x ⊕ 1. At counter 0, go to CMP.
  - CMP: on_curve ← (t1 == acc ⊕ b). Pulse `done`, return to IDLE.
- `clr` has priority over `start` and over every state transition. It forces IDLE, done = 0 and on_curve = 0. Datapath registers may keep stale values.
- `start` outside IDLE is ignored. It is neither queued nor allowed to restart the operation.
- Reset asserted mid-operation: all state is lost, and the block leaves reset in IDLE with no `done`.

## Timing
- Reset values: done = 0, on_curve = 0, state = IDLE, counter = 0, acc = 0, t1 = t2 = 0, latched x and y = 0.
- Edge numbering: E0 is the edge that samples `start` in IDLE.
- M1 occupies edges E1–E163, M2 occupies E164–E326, M3 occupies E327–E489, and CMP falls on E490.
- `done` is high for exactly one cycle, after E490. Latency is 490 cycles from start to done.
- A new `start` is accepted in the cycle after `done` is asserted. It may be asserted while `done` is high, because the state is IDLE again by then.
- `on_curve` changes only at CMP, at `clr`, at reset, or when cleared to 0 on an accepted `start`.

## Configuration
- `SECT163R2_PT_CHK_INF_EN`
  - Defined: an input (x, y) = (0, 0) is treated as the point at infinity. At E0 the FSM goes straight to CMP, so `done` is high after E1 with on_curve = 1. All other inputs take the full 490-cycle path.
  - Undefined: (0, 0) takes the normal path. The identity then evaluates as 0 == b, so the result is on_curve = 0 after 490 cycles.

## Test plan
- Generator point, x = 0x3F0EBA16286A2D57EA0991168D4994637E8343E36 and y = 0x0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1, with one `start` pulse → `done` exactly 490 cycles later, on_curve = 1.
- Same x, y with bit 0 flipped (…4F0) → `done` at 490 cycles, on_curve = 0. The same result is required for x with bit 162 flipped.
- (0, 0) → with the macro: `done` after 1 cycle, on_curve = 1. Without the macro: `done` after 490 cycles, on_curve = 0.
- Second `start` pulse at cycle 100 of an operation → ignored. Exactly one `done` at cycle 490, carrying the result of the first operands.
- `clr` at cycle 200 → no `done`, on_curve = 0. A new `start` with the generator point then returns on_curve = 1 after 490 cycles.
- `rst_n` low at cycle 300 of an operation → done = on_curve = 0 immediately, without waiting for a clock edge. After release, the block is in IDLE and completes a fresh check correctly.
